// File: rtl/proc_sequencer_pkg.sv
// Shared definitions for the program sequencer: widths, opcodes, state encoding
// and the PC control encoding used between the top and its PC sub-module.
package proc_pkg;

    localparam int WORD_W  = 9;
    localparam int ADDR_W  = 5;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 3;
    localparam int WAIT_W  = $clog2(TIMEOUT);

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_DATA  = 3'd3,
        S_WAIT  = 3'd4,
        S_HALT  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_ZERO = 2'd1,
        PC_INC1 = 2'd2,
        PC_INC2 = 2'd3
    } pc_op_e;

    function automatic logic [2:0] opcode_of(input logic [WORD_W-1:0] word);
        return word[WORD_W-1 -: 3];
    endfunction

endpackage

// File: rtl/proc_sequencer_seq_pc.sv
// Program counter for the sequencer: load-zero, +1 and +2 steps, wrapping
// naturally at the 5-bit address width.
module seq_pc
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  pc_op_e            pc_op_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_inc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // NOTE: the next value is given its hold default before the case; a path
    // that skipped the assignment would otherwise infer a latch.
    always_comb begin
        pc_d = pc_q;
        case (pc_op_i)
            PC_ZERO: pc_d = '0;
            PC_INC1: pc_d = pc_q + ADDR_W'(1);
            PC_INC2: pc_d = pc_q + ADDR_W'(2);
            default: pc_d = pc_q;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // values present before the edge, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o     = pc_q;
    assign pc_inc_o = pc_q + ADDR_W'(1);

endmodule

// File: rtl/proc_sequencer.sv
// Fetches 9-bit instruction words from program memory and hands them to the
// processor; optional single-step control is enabled by PROC_SEQUENCER_STEP_EN.
module proc_sequencer
    import proc_pkg::*;
(
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
`ifdef PROC_SEQUENCER_STEP_EN
    input  logic              Step,
`endif
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [WORD_W-1:0] MemData,
    output logic [WORD_W-1:0] DIN,
    output logic              Run,
    input  logic              Done,
    output logic              Busy,
    output logic              Halted,
    output logic              IllegalOp,
    output logic [CNT_W-1:0]  InstrCount
);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;
    logic               illegal_q, illegal_d;

    pc_op_e             pc_op;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  mem_addr;
    logic [WORD_W-1:0]  din;
    logic               run;
    logic               retire;
    logic               fetch_go;

    seq_pc u_seq_pc (
        .clk      (Clock),
        .rst_n    (Resetn),
        .pc_op_i  (pc_op),
        .pc_o     (pc),
        .pc_inc_o (pc_inc)
    );

`ifdef PROC_SEQUENCER_STEP_EN
    assign fetch_go = Step;
`else
    assign fetch_go = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        instr_cnt_d = instr_cnt_q;
        illegal_d   = illegal_q;
        pc_op       = PC_HOLD;
        retire      = 1'b0;
        mem_addr    = pc;
        din         = '0;
        run         = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (Start) begin
                    pc_op       = PC_ZERO;
                    instr_cnt_d = '0;
                    illegal_d   = 1'b0;
                    state_d     = S_FETCH;
                end
            end

            S_FETCH: begin
                if (fetch_go) begin
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                din        = MemData;
                wait_cnt_d = '0;
                case (opcode_of(MemData))
                    OP_HALT: begin
                        state_d = S_HALT;
                    end
                    OP_MVI: begin
                        run      = 1'b1;
                        mem_addr = pc_inc;
                        state_d  = S_DATA;
                    end
                    OP_MV, OP_ADD, OP_SUB: begin
                        run      = 1'b1;
                        mem_addr = pc_inc;
                        state_d  = S_WAIT;
                    end
                    default: begin
                        // Unknown opcodes are still issued; the timeout flags them.
                        run      = 1'b1;
                        mem_addr = pc_inc;
                        state_d  = S_WAIT;
                    end
                endcase
            end

            S_DATA: begin
                din     = MemData;
                retire  = 1'b1;
                pc_op   = PC_INC2;
                state_d = S_FETCH;
            end

            S_WAIT: begin
                if (Done) begin
                    retire  = 1'b1;
                    pc_op   = PC_INC1;
                    state_d = S_FETCH;
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                    illegal_d = 1'b1;
                    pc_op     = PC_INC1;
                    state_d   = S_FETCH;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (retire && (instr_cnt_q != '1)) begin
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            instr_cnt_q <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            instr_cnt_q <= instr_cnt_d;
            illegal_q   <= illegal_d;
        end
    end

    // Outputs decode from the asynchronously reset state, so reset takes effect at once.
    assign MemAddr    = mem_addr;
    assign DIN        = din;
    assign Run        = run;
    assign Busy       = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
                        (state_q == S_DATA)  || (state_q == S_WAIT);
    assign Halted     = (state_q == S_HALT);
    assign IllegalOp  = illegal_q;
    assign InstrCount = instr_cnt_q;

endmodule

// File: doc/proc_sequencer.md
PROC_SEQUENCER -- requirements
Module: proc_sequencer

Interface
REQ-001 SHALL have port Clock, input, 1, sole clock; all state changes on its rising edge.
REQ-002 SHALL have port Resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port Start, input, 1, one-cycle request to run the program from address 0.
REQ-004 SHALL have port MemAddr, output, 5, program memory read address.
REQ-005 SHALL have port MemData, input, 9, program memory read data, valid one cycle after MemAddr.
REQ-006 SHALL have port DIN, output, 9, instruction/data word to the processor.
REQ-007 SHALL have port Run, output, 1, processor run request.
REQ-008 SHALL have port Done, input, 1, processor instruction-complete flag (combinational, valid in the same cycle).
REQ-009 SHALL have ports Busy, Halted and IllegalOp, output, 1 each: program executing; halt reached; sticky flag for an unknown opcode.
REQ-010 SHALL have port InstrCount, output, 8, count of retired instructions.

Function
REQ-011 States: IDLE, FETCH, ISSUE, DATA, WAIT, HALT.
REQ-012 IDLE: Start=1 -> PC=0, clear InstrCount/IllegalOp/Halted, go FETCH; Start is ignored in every other state except HALT.
REQ-013 FETCH: MemAddr=PC for one cycle, then go ISSUE.
REQ-014 ISSUE: DIN=MemData; if MemData[8:6]=3'b111 (halt) then Run=0, go HALT; else Run=1 combinationally, MemAddr=PC+1, go DATA if opcode=mvi (001), else WAIT.
REQ-015 DATA: DIN=MemData (word at PC+1), Run=0; processor Done is expected this cycle; go FETCH with PC+=2 and InstrCount+=1.
REQ-016 WAIT: Run=0, DIN=0; Done=1 -> PC+=1, InstrCount+=1, go FETCH.
REQ-017 Timeout: an issued instruction that has not asserted Done by the third cycle after ISSUE SHALL set IllegalOp, advance PC by 1, and go FETCH on the fourth cycle. The counter does not increment InstrCount in this case.
REQ-018 mv completes in the cycle after ISSUE, add/sub three cycles after ISSUE, and opcodes 100-110 time out per REQ-017.
REQ-019 PC is 5 bits and wraps from 31 to 0; mvi at address 31 takes its data word from address 0, and its next PC is 1.
REQ-020 InstrCount saturates at 255.
REQ-021 HALT: Halted=1, Run=0; Start=1 restarts exactly as from IDLE.
REQ-022 Busy=1 in FETCH/ISSUE/DATA/WAIT, else 0.
REQ-023 Run SHALL never be 1 outside ISSUE.
REQ-024 DIN=0 outside ISSUE/DATA.

Reset
REQ-025 Resetn=0 SHALL immediately force IDLE, PC=0, MemAddr=0, Run=0, DIN=0, Busy=0, Halted=0, IllegalOp=0, InstrCount=0, regardless of the current state, including mid-instruction.
REQ-026 The processor's own reset is driven by the same Resetn, so no in-flight instruction survives reset.

Configuration
REQ-027 With macro PROC_SEQUENCER_STEP_EN defined: the block SHALL add input Step (1 bit), and FETCH SHALL hold, with MemAddr stable, until Step=1, issuing exactly one instruction per Step pulse.
REQ-028 Without PROC_SEQUENCER_STEP_EN: there is no Step port, and FETCH always advances after one cycle.

Structure
REQ-029 Shared package proc_pkg SHALL hold WORD_W=9, ADDR_W=5, opcode constants (mv=000, mvi=001, add=010, sub=011, halt=111), the state encoding, and TIMEOUT=3.
REQ-030 A single sub-module seq_pc SHALL implement the PC register, with load-zero, +1 and +2 controls and 5-bit wrap; all other logic stays in proc_sequencer.

Verification
REQ-031 Program {mvi r0,#5; mvi r1,#3; add r0,r1; halt} -> Run pulses 3 times; processor r0=8; Halted=1; InstrCount=3; IllegalOp=0.
REQ-032 sub r2,r2 at address 0, then halt -> Run high for exactly 1 cycle; WAIT lasts until Done at ISSUE+3; PC=1 at halt.
REQ-033 Opcode 101 at address 0, then halt -> IllegalOp=1 after 4 cycles; InstrCount=0; Halted=1.
REQ-034 mvi r3 at address 31 with word 9'h0AA at address 0, entered by jumping the PC -> r3=0x0AA; next fetch MemAddr=1.
REQ-035 Resetn asserted during WAIT of an add -> all outputs at their reset values in the same cycle; Start afterwards reruns from address 0.
REQ-036 With PROC_SEQUENCER_STEP_EN defined: no Step for 10 cycles -> MemAddr is held and Run=0; each Step pulse retires exactly one instruction.
